// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures the decoded control bundle and operand
// data from ID and presents it to EX/MEM/WB. Supports hold (freeze), flush
// (bubble insertion) and a valid bit; a bubble never carries a write enable.
module id_ex_pipeline_reg #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int PC_W   = 32,
  parameter int RA_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_is_load,
  input  logic              id_fl_write_enable,
  input  logic              id_alu_src_mux,
  input  logic              id_mem_write_enable,
  input  logic              id_sel_beq_bne,
  input  logic              id_sel_jt_jf,
  input  logic              id_is_branch,
  input  logic              id_sel_jflag_branch,
  input  logic              id_reg_write_enable,
  input  logic [5:0]        id_alu_funct,
  input  logic [1:0]        id_reg_dst_mux,
  input  logic [1:0]        id_wb_res_mux,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic [RA_W-1:0]   id_rs_addr,
  input  logic [RA_W-1:0]   id_rt_addr,
  input  logic [RA_W-1:0]   id_rd_addr,
  input  logic [PC_W-1:0]   id_pc_next,
  output logic              ex_valid,
  output logic              ex_is_load,
  output logic              ex_fl_write_enable,
  output logic              ex_alu_src_mux,
  output logic              ex_mem_write_enable,
  output logic              ex_sel_beq_bne,
  output logic              ex_sel_jt_jf,
  output logic              ex_is_branch,
  output logic              ex_sel_jflag_branch,
  output logic              ex_reg_write_enable,
  output logic [5:0]        ex_alu_funct,
  output logic [1:0]        ex_reg_dst_mux,
  output logic [1:0]        ex_wb_res_mux,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [IMM_W-1:0]  ex_imm,
  output logic [RA_W-1:0]   ex_rs_addr,
  output logic [RA_W-1:0]   ex_rt_addr,
  output logic [RA_W-1:0]   ex_rd_addr,
  output logic [PC_W-1:0]   ex_pc_next
);

  // Priority rst > flush > hold > load; reset and bubble both clear every field,
  // and on load the five side-effecting bits are qualified by id_valid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid            <= 1'b0;
      ex_is_load          <= 1'b0;
      ex_fl_write_enable  <= 1'b0;
      ex_alu_src_mux      <= 1'b0;
      ex_mem_write_enable <= 1'b0;
      ex_sel_beq_bne      <= 1'b0;
      ex_sel_jt_jf        <= 1'b0;
      ex_is_branch        <= 1'b0;
      ex_sel_jflag_branch <= 1'b0;
      ex_reg_write_enable <= 1'b0;
      ex_alu_funct        <= '0;
      ex_reg_dst_mux      <= '0;
      ex_wb_res_mux       <= '0;
      ex_rs_data          <= '0;
      ex_rt_data          <= '0;
      ex_imm              <= '0;
      ex_rs_addr          <= '0;
      ex_rt_addr          <= '0;
      ex_rd_addr          <= '0;
      ex_pc_next          <= '0;
    end else if (!hold) begin
      ex_valid            <= id_valid;
      ex_is_load          <= id_valid & id_is_load;
      ex_fl_write_enable  <= id_valid & id_fl_write_enable;
      ex_alu_src_mux      <= id_alu_src_mux;
      ex_mem_write_enable <= id_valid & id_mem_write_enable;
      ex_sel_beq_bne      <= id_sel_beq_bne;
      ex_sel_jt_jf        <= id_sel_jt_jf;
      ex_is_branch        <= id_valid & id_is_branch;
      ex_sel_jflag_branch <= id_sel_jflag_branch;
      ex_reg_write_enable <= id_valid & id_reg_write_enable;
      ex_alu_funct        <= id_alu_funct;
      ex_reg_dst_mux      <= id_reg_dst_mux;
      ex_wb_res_mux       <= id_wb_res_mux;
      ex_rs_data          <= id_rs_data;
      ex_rt_data          <= id_rt_data;
      ex_imm              <= id_imm;
      ex_rs_addr          <= id_rs_addr;
      ex_rt_addr          <= id_rt_addr;
      ex_rd_addr          <= id_rd_addr;
      ex_pc_next          <= id_pc_next;
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed testbench for id_ex_pipeline_reg.
module tb_id_ex_pipeline_reg;

  typedef struct packed {
    logic        valid;
    logic        is_load;
    logic        fl_write_enable;
    logic        alu_src_mux;
    logic        mem_write_enable;
    logic        sel_beq_bne;
    logic        sel_jt_jf;
    logic        is_branch;
    logic        sel_jflag_branch;
    logic        reg_write_enable;
    logic [5:0]  alu_funct;
    logic [1:0]  reg_dst_mux;
    logic [1:0]  wb_res_mux;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic [3:0]  rd_addr;
    logic [31:0] pc_next;
  } bundle_t;

  logic    clk = 1'b0;
  logic    rst, hold, flush;
  bundle_t id_b;
  bundle_t ex_b;
  bundle_t exp_b;
  int      vectors = 0;
  int      miscompares = 0;

  logic        ex_valid, ex_is_load, ex_fl_write_enable, ex_alu_src_mux;
  logic        ex_mem_write_enable, ex_sel_beq_bne, ex_sel_jt_jf, ex_is_branch;
  logic        ex_sel_jflag_branch, ex_reg_write_enable;
  logic [5:0]  ex_alu_funct;
  logic [1:0]  ex_reg_dst_mux, ex_wb_res_mux;
  logic [31:0] ex_rs_data, ex_rt_data, ex_pc_next;
  logic [15:0] ex_imm;
  logic [3:0]  ex_rs_addr, ex_rt_addr, ex_rd_addr;

  assign ex_b = {ex_valid, ex_is_load, ex_fl_write_enable, ex_alu_src_mux,
                 ex_mem_write_enable, ex_sel_beq_bne, ex_sel_jt_jf, ex_is_branch,
                 ex_sel_jflag_branch, ex_reg_write_enable, ex_alu_funct,
                 ex_reg_dst_mux, ex_wb_res_mux, ex_rs_data, ex_rt_data, ex_imm,
                 ex_rs_addr, ex_rt_addr, ex_rd_addr, ex_pc_next};

  always #5 clk = ~clk;

  id_ex_pipeline_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .hold                (hold),
    .flush               (flush),
    .id_valid            (id_b.valid),
    .id_is_load          (id_b.is_load),
    .id_fl_write_enable  (id_b.fl_write_enable),
    .id_alu_src_mux      (id_b.alu_src_mux),
    .id_mem_write_enable (id_b.mem_write_enable),
    .id_sel_beq_bne      (id_b.sel_beq_bne),
    .id_sel_jt_jf        (id_b.sel_jt_jf),
    .id_is_branch        (id_b.is_branch),
    .id_sel_jflag_branch (id_b.sel_jflag_branch),
    .id_reg_write_enable (id_b.reg_write_enable),
    .id_alu_funct        (id_b.alu_funct),
    .id_reg_dst_mux      (id_b.reg_dst_mux),
    .id_wb_res_mux       (id_b.wb_res_mux),
    .id_rs_data          (id_b.rs_data),
    .id_rt_data          (id_b.rt_data),
    .id_imm              (id_b.imm),
    .id_rs_addr          (id_b.rs_addr),
    .id_rt_addr          (id_b.rt_addr),
    .id_rd_addr          (id_b.rd_addr),
    .id_pc_next          (id_b.pc_next),
    .ex_valid            (ex_valid),
    .ex_is_load          (ex_is_load),
    .ex_fl_write_enable  (ex_fl_write_enable),
    .ex_alu_src_mux      (ex_alu_src_mux),
    .ex_mem_write_enable (ex_mem_write_enable),
    .ex_sel_beq_bne      (ex_sel_beq_bne),
    .ex_sel_jt_jf        (ex_sel_jt_jf),
    .ex_is_branch        (ex_is_branch),
    .ex_sel_jflag_branch (ex_sel_jflag_branch),
    .ex_reg_write_enable (ex_reg_write_enable),
    .ex_alu_funct        (ex_alu_funct),
    .ex_reg_dst_mux      (ex_reg_dst_mux),
    .ex_wb_res_mux       (ex_wb_res_mux),
    .ex_rs_data          (ex_rs_data),
    .ex_rt_data          (ex_rt_data),
    .ex_imm              (ex_imm),
    .ex_rs_addr          (ex_rs_addr),
    .ex_rt_addr          (ex_rt_addr),
    .ex_rd_addr          (ex_rd_addr),
    .ex_pc_next          (ex_pc_next)
  );

  // Expected result of a plain load: invalid entries lose their five enables.
  function automatic bundle_t gated(input bundle_t b);
    bundle_t r;
    r = b;
    if (!b.valid) begin
      r.is_load          = 1'b0;
      r.fl_write_enable  = 1'b0;
      r.mem_write_enable = 1'b0;
      r.is_branch        = 1'b0;
      r.reg_write_enable = 1'b0;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic random_id();
    logic [159:0] raw;
    raw  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    id_b = bundle_t'(raw[143:0]);
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    id_b = '1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (ex_b !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_cycle%0d: got %h expected 0", i, ex_b);
      end
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (ex_b !== bundle_t'('1)) begin
      miscompares++;
      $display("[TB] FAIL reset_release_load: got %h expected all ones", ex_b);
    end
  endtask

  task automatic test_normal_load();
    id_b = '0;
    id_b.valid = 1'b1;
    id_b.alu_funct = 6'h20;
    id_b.rs_data = 32'h0000_0005;
    id_b.rt_data = 32'hFFFF_FFFE;
    id_b.rd_addr = 4'd7;
    id_b.reg_write_enable = 1'b1;
    tick();
    vectors++;
    if (ex_b !== id_b) begin
      miscompares++;
      $display("[TB] FAIL normal_load: got %h expected %h", ex_b, id_b);
    end
    vectors++;
    if (ex_rt_data !== 32'hFFFF_FFFE || ex_rd_addr !== 4'd7 || ex_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL normal_load_fields: rt=%h rd=%0d valid=%b expected fffffffe 7 1",
               ex_rt_data, ex_rd_addr, ex_valid);
    end
  endtask

  task automatic test_hold();
    bundle_t held;
    held = ex_b;
    exp_b = id_b;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      random_id();
      tick();
      vectors++;
      if (ex_b !== exp_b) begin
        miscompares++;
        $display("[TB] FAIL hold_cycle%0d: got %h expected %h", i, ex_b, exp_b);
      end
    end
    hold = 1'b0;
    id_b.valid = 1'b0;
    id_b.reg_write_enable = 1'b1;
    tick();
    vectors++;
    if (ex_b !== gated(id_b) || ex_b === held) begin
      miscompares++;
      $display("[TB] FAIL hold_release: got %h expected %h", ex_b, gated(id_b));
    end
  endtask

  task automatic test_flush_priority();
    random_id();
    id_b.valid = 1'b1;
    id_b.mem_write_enable = 1'b1;
    tick();
    vectors++;
    if (ex_b !== id_b) begin
      miscompares++;
      $display("[TB] FAIL store_load: got %h expected %h", ex_b, id_b);
    end
    flush = 1'b1; hold = 1'b1;
    tick();
    vectors++;
    if (ex_b !== '0) begin
      miscompares++;
      $display("[TB] FAIL flush_over_hold: got %h expected 0", ex_b);
    end
    vectors++;
    if (ex_mem_write_enable !== 1'b0 || ex_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_store_kill: mem_we=%b valid=%b expected 0 0",
               ex_mem_write_enable, ex_valid);
    end
    flush = 1'b0; hold = 1'b0;
  endtask

  task automatic test_back_to_back();
    flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      random_id();
      id_b.valid = 1'b1;
      id_b.reg_write_enable = 1'b1;
      tick();
      vectors++;
      if (ex_b !== '0) begin
        miscompares++;
        $display("[TB] FAIL back_to_back_flush%0d: got %h expected 0", i, ex_b);
      end
    end
    flush = 1'b0;
    tick();
    vectors++;
    if (ex_b !== id_b) begin
      miscompares++;
      $display("[TB] FAIL load_after_flush: got %h expected %h", ex_b, id_b);
    end
  endtask

  task automatic test_invalid_gating();
    id_b = '0;
    id_b.valid = 1'b0;
    id_b.reg_write_enable = 1'b1;
    id_b.mem_write_enable = 1'b1;
    id_b.is_branch = 1'b1;
    id_b.is_load = 1'b1;
    id_b.fl_write_enable = 1'b1;
    id_b.alu_src_mux = 1'b1;
    id_b.rs_data = 32'hDEAD_BEEF;
    tick();
    vectors++;
    if ({ex_reg_write_enable, ex_mem_write_enable, ex_is_branch, ex_is_load,
         ex_fl_write_enable, ex_valid} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL invalid_gating: we/mw/br/ld/fl/valid=%b%b%b%b%b%b expected 000000",
               ex_reg_write_enable, ex_mem_write_enable, ex_is_branch, ex_is_load,
               ex_fl_write_enable, ex_valid);
    end
    vectors++;
    if (ex_rs_data !== 32'hDEAD_BEEF || ex_alu_src_mux !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL invalid_passthrough: rs=%h alu_src=%b expected deadbeef 1",
               ex_rs_data, ex_alu_src_mux);
    end
  endtask

  task automatic test_jal();
    id_b = '0;
    id_b.valid = 1'b1;
    id_b.reg_dst_mux = 2'b10;
    id_b.wb_res_mux = 2'b10;
    id_b.pc_next = 32'h0000_0101;
    id_b.reg_write_enable = 1'b1;
    tick();
    vectors++;
    if (ex_reg_dst_mux !== 2'b10 || ex_wb_res_mux !== 2'b10 ||
        ex_pc_next !== 32'h0000_0101 || ex_reg_write_enable !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL jal_passthrough: dst=%b wb=%b pc=%h we=%b expected 10 10 00000101 1",
               ex_reg_dst_mux, ex_wb_res_mux, ex_pc_next, ex_reg_write_enable);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (ex_b !== '0) begin
      miscompares++;
      $display("[TB] FAIL jal_then_reset: got %h expected 0", ex_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    random_id();
    id_b.valid = 1'b1;
    tick();
    vectors++;
    if (ex_b !== id_b) begin
      miscompares++;
      $display("[TB] FAIL pre_hold_load: got %h expected %h", ex_b, id_b);
    end
    hold = 1'b1; rst = 1'b1;
    tick();
    vectors++;
    if (ex_b !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_hold: got %h expected 0", ex_b);
    end
    rst = 1'b0; hold = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0; id_b = '0;
    test_reset();
    test_normal_load();
    test_hold();
    test_flush_priority();
    test_back_to_back();
    test_invalid_gating();
    test_jal();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_reg.md
# id_ex_pipeline_reg

ID/EX pipeline register for the LAPI DOpaCA LAMBA core. It sits directly downstream of the control unit and register file. Each cycle it captures the decoded control bundle and the operand data, and presents them to the EX, MEM and WB stages. It supports hold (freeze), flush (bubble insertion) and a valid bit, and it guarantees that a bubble never carries an active write enable.

## Interface
Parameters:
- DATA_W, 32, register-file operand width
- IMM_W, 16, immediate field width (already sign/zero-extended upstream is NOT assumed; stored raw)
- PC_W, 32, width of the pc+1 value
- RA_W, 4, register address width (r0..r15)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- hold  in  1  freeze register contents (hazard stall of EX)
- flush  in  1  replace contents with a bubble (taken branch/jump squash)
- id_valid  in  1  ID stage holds a real instruction
- id_is_load, id_fl_write_enable, id_alu_src_mux, id_mem_write_enable, id_sel_beq_bne, id_sel_jt_jf, id_is_branch, id_sel_jflag_branch, id_reg_write_enable  in  1 each  control bits from control unit
- id_alu_funct  in  6  ALU operation
- id_reg_dst_mux, id_wb_res_mux  in  2 each  destination / writeback selects
- id_rs_data, id_rt_data  in  DATA_W  register operands
- id_imm  in  IMM_W  immediate
- id_rs_addr, id_rt_addr, id_rd_addr  in  RA_W  register addresses (forwarding/destination)
- id_pc_next  in  PC_W  pc+1 (JAL link value)
- ex_* outputs  out  same widths  registered copies of every id_* input above
- ex_valid  out  1  registered id_valid

## Operation
- Per-cycle update priority: rst > flush > hold > load.
- **rst:** every ex_* output and ex_valid go to 0. This includes the data, address and selector fields.
- **flush:** loads a bubble.
  - ex_valid = 0.
  - ex_reg_write_enable, ex_mem_write_enable, ex_fl_write_enable, ex_is_branch, ex_is_load = 0.
  - All other fields = 0.
- **hold (no flush):** all outputs retain their previous values, including ex_valid.
- **load:** every ex_* output takes its id_* counterpart.
  - Gating: if id_valid = 0, the five enables/qualifiers (reg_write, mem_write, fl_write, is_branch, is_load) are forced to 0 regardless of their inputs.
- Selector and funct inputs the control unit leaves as don't-care (x) are captured unmodified on load. On reset and flush they are 0. Downstream consumes them only when the matching enable is 1.
- No combinational path from any input to any output.

## Timing
- Latency: exactly 1 cycle from id_* at edge N to ex_* valid after edge N.
- **Hold:** held for every cycle hold = 1, with no limit on duration. The first edge with hold = 0 loads the id_* values present at that edge.
- **flush and hold both high:** flush wins, and a bubble is loaded.
- **Reset mid-hold or mid-flush:** reset wins, and outputs are 0 at the next edge.
- **Back-to-back flushes:** one bubble per cycle, with no accumulation.
- **After rst deasserts:** the first edge performs a normal load if hold = 0 and flush = 0.
- **Load-use interaction:** the control unit already zeroes enables under stall_pipeline. This block does not see stall_pipeline, and it treats the resulting zeroed bundle as an ordinary load.

## Test plan
- **Reset:** drive all id_* = 1s, rst = 1 for 2 cycles -> all ex_* = 0, ex_valid = 0. Release rst with hold = 0 and flush = 0 -> the next edge shows the id_* values.
- **Normal load:**
  - Stimulus: id_valid = 1, id_alu_funct = 6'h20, id_rs_data = 32'h0000_0005, id_rt_data = 32'hFFFF_FFFE, id_rd_addr = 4'd7, id_reg_write_enable = 1.
  - Required response: one edge later the ex_* outputs match the inputs exactly and ex_valid = 1.
- **Hold:** load the bundle above, then hold = 1 for 3 cycles while id_* change to random values -> ex_* stay at the bundle values. Release hold -> the current id_* appear after 1 edge.
- **Flush priority:** with a valid store bundle loaded (mem_write_enable = 1), assert flush = 1 and hold = 1 together -> ex_valid = 0, ex_mem_write_enable = 0, all fields 0 after 1 edge.
- **Invalid-entry gating:** id_valid = 0 with id_reg_write_enable = 1, id_mem_write_enable = 1, id_is_branch = 1, id_is_load = 1, id_fl_write_enable = 1, id_rs_data = 32'hDEAD_BEEF -> those five ex_* bits = 0, ex_rs_data = 32'hDEAD_BEEF, ex_valid = 0.
- **JAL passthrough:**
  - Stimulus: id_reg_dst_mux = 2'b10, id_wb_res_mux = 2'b10, id_pc_next = 32'h0000_0101, id_reg_write_enable = 1.
  - Required response: the ex_* copies match after 1 edge. A reset asserted in the following cycle zeroes them at the next edge.
